// File: rtl/rtc_bridge_pkg.sv
// Shared definitions for the machine-timer bus bridge: register offsets,
// FSM state encoding and the response data source select.
package rtc_bridge_pkg;

    localparam logic [3:0] RTC_MTIME_LO    = 4'h0;
    localparam logic [3:0] RTC_MTIME_HI    = 4'h4;
    localparam logic [3:0] RTC_MTIMECMP_LO = 4'h8;
    localparam logic [3:0] RTC_MTIMECMP_HI = 4'hC;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        IDLE  = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEL_ZERO  = 2'd0,
        SEL_TIMER = 2'd1,
        SEL_SNAP  = 2'd2
    } rsp_sel_t;

endpackage

// File: rtl/rtc_bridge_if.sv
// Core-side 32-bit peripheral request/response bus. The master is the
// interconnect; the slave is the timer bridge.
interface rtc_bridge_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic [3:0]  req_we_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    modport master (
        output req_valid_i, req_addr_i, req_we_i, req_wdata_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, req_we_i, req_wdata_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/rtc_bridge.sv
// Bridges 32-bit bus words onto the 64-bit mtime/mtimecmp block and keeps a
// high-word snapshot so a lo-then-hi read pair of mtime never tears.
module rtc_bridge
    import rtc_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0800_0000
) (
    input  logic         clk,
    input  logic         reset_n,
    rtc_bridge_if.slave  bus,
    output logic         rtc_en_o,
    output logic [3:0]   rtc_addr_o,
    output logic [7:0]   rtc_we_o,
    output logic [63:0]  rtc_data_o,
    input  logic [63:0]  rtc_data_i,
    input  logic [63:0]  rtc_mtime_i
);

    state_t      state_r;
    state_t      next_state_s;
    rsp_sel_t    sel_r;
    logic        err_r;
    logic [31:0] snap_hi_r;
    logic        snap_vld_r;

    logic        ready_s;
    logic        rsp_active_s;
    logic [31:0] rdata_s;
    logic        err_s;
    logic        hit_s;
    logic        handshake_s;
    logic        is_read_s;
    logic [3:0]  offset_s;
    logic        unused_s;

    assign offset_s    = bus.req_addr_i[3:0];
    assign hit_s       = (bus.req_addr_i[31:4] == BASE_ADDR[31:4]) &&
                         (bus.req_addr_i[1:0] == 2'b00);
    assign is_read_s   = (bus.req_we_i == 4'b0000);
    assign handshake_s = bus.req_valid_i & ready_s;

    // Timer only sees accepted hits; the timer itself decodes the offset.
    assign rtc_en_o    = handshake_s & hit_s;
    assign rtc_addr_o  = offset_s;
    assign rtc_we_o    = {4'b0000, bus.req_we_i};
    assign rtc_data_o  = {32'h0000_0000, bus.req_wdata_i};
    assign unused_s    = ^rtc_data_i[63:32];

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= RESET;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            RESET: next_state_s = IDLE;
            IDLE: begin
                if (handshake_s) next_state_s = RESP;
                else             next_state_s = IDLE;
            end
            RESP: begin
                if (bus.rsp_ready_i) next_state_s = IDLE;
                else                 next_state_s = RESP;
            end
            default: next_state_s = RESET;
        endcase
    end

    // FSM outputs; read data comes from the registered select so it stays
    // stable under back-pressure (the timer's read register is idle in RESP).
    always_comb begin
        ready_s      = 1'b0;
        rsp_active_s = 1'b0;
        rdata_s      = 32'h0000_0000;
        err_s        = 1'b0;
        case (state_r)
            RESET: ready_s = 1'b0;
            IDLE:  ready_s = 1'b1;
            RESP: begin
                rsp_active_s = 1'b1;
                err_s        = err_r;
                case (sel_r)
                    SEL_ZERO:  rdata_s = 32'h0000_0000;
                    SEL_TIMER: rdata_s = rtc_data_i[31:0];
                    SEL_SNAP:  rdata_s = snap_hi_r;
                    default:   rdata_s = 32'h0000_0000;
                endcase
            end
            default: ready_s = 1'b0;
        endcase
    end

    assign bus.req_ready_o = ready_s;
    assign bus.rsp_valid_o = rsp_active_s;
    assign bus.rsp_rdata_o = rdata_s;
    assign bus.rsp_err_o   = err_s;

    // Response kind captured at the request handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_r <= SEL_ZERO;
            err_r <= 1'b0;
        end else if (handshake_s) begin
            if (!hit_s) begin
                sel_r <= SEL_ZERO;
                err_r <= 1'b1;
            end else if (!is_read_s) begin
                sel_r <= SEL_ZERO;
                err_r <= 1'b0;
            end else if ((offset_s == RTC_MTIME_HI) && snap_vld_r) begin
                sel_r <= SEL_SNAP;
                err_r <= 1'b0;
            end else begin
                sel_r <= SEL_TIMER;
                err_r <= 1'b0;
            end
        end
    end

    // mtime high-word snapshot: armed by a lo read, consumed or cancelled by
    // any hi access and cancelled by a lo write; mtimecmp leaves it alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_hi_r  <= 32'h0000_0000;
            snap_vld_r <= 1'b0;
        end else if (handshake_s && hit_s) begin
            case (offset_s)
                RTC_MTIME_LO: begin
                    if (is_read_s) begin
                        snap_hi_r  <= rtc_mtime_i[63:32];
                        snap_vld_r <= 1'b1;
                    end else begin
                        snap_vld_r <= 1'b0;
                    end
                end
                RTC_MTIME_HI: snap_vld_r <= 1'b0;
                default:      snap_vld_r <= snap_vld_r;
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_bridge.sv
// Directed bench for rtc_bridge with a small behavioural mtime/mtimecmp block
// that counts every cycle and registers read data on the access strobe.
module tb_rtc_bridge;

    localparam logic [31:0] BASE = 32'h0800_0000;

    logic        clk;
    logic        reset_n;
    logic        timer_rst_n;
    logic        rtc_en;
    logic [3:0]  rtc_addr;
    logic [7:0]  rtc_we;
    logic [63:0] rtc_wdata;
    logic [63:0] rtc_rdata;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [31:0] rd;
    logic        er;
    int          checks;
    int          failures;

    rtc_bridge_if bus ();

    rtc_bridge #(.BASE_ADDR(BASE)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .rtc_en_o    (rtc_en),
        .rtc_addr_o  (rtc_addr),
        .rtc_we_o    (rtc_we),
        .rtc_data_o  (rtc_wdata),
        .rtc_data_i  (rtc_rdata),
        .rtc_mtime_i (mtime)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0]  be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return r;
    endfunction

    // Timer model; its reset is separate so mtime survives a bridge reset.
    always @(posedge clk or negedge timer_rst_n) begin
        if (!timer_rst_n) begin
            mtime     <= 64'd0;
            mtimecmp  <= 64'd0;
            rtc_rdata <= 64'd0;
        end else begin
            if (rtc_en && (rtc_we != 8'h00) && (rtc_addr == 4'h0))
                mtime <= {mtime[63:32], merge(mtime[31:0], rtc_wdata[31:0], rtc_we[3:0])};
            else if (rtc_en && (rtc_we != 8'h00) && (rtc_addr == 4'h4))
                mtime <= {merge(mtime[63:32], rtc_wdata[31:0], rtc_we[3:0]), mtime[31:0]};
            else
                mtime <= mtime + 64'd1;
            if (rtc_en && (rtc_we != 8'h00) && (rtc_addr == 4'h8))
                mtimecmp <= {mtimecmp[63:32], merge(mtimecmp[31:0], rtc_wdata[31:0], rtc_we[3:0])};
            else if (rtc_en && (rtc_we != 8'h00) && (rtc_addr == 4'hC))
                mtimecmp <= {merge(mtimecmp[63:32], rtc_wdata[31:0], rtc_we[3:0]), mtimecmp[31:0]};
            if (rtc_en && (rtc_we == 8'h00)) begin
                case (rtc_addr)
                    4'h0:    rtc_rdata <= {32'h0, mtime[31:0]};
                    4'h4:    rtc_rdata <= {32'h0, mtime[63:32]};
                    4'h8:    rtc_rdata <= {32'h0, mtimecmp[31:0]};
                    4'hC:    rtc_rdata <= {32'h0, mtimecmp[63:32]};
                    default: rtc_rdata <= 64'd0;
                endcase
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction, entered and left on a falling edge.
    task automatic do_req(input string tag, input logic [31:0] addr,
                          input logic [3:0] we, input logic [31:0] wdata,
                          input logic exp_hit,
                          output logic [31:0] rdata, output logic err);
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = addr;
        bus.req_we_i    = we;
        bus.req_wdata_i = wdata;
        bus.rsp_ready_i = 1'b1;
        #1;
        chk({tag, "_ready"}, {63'd0, bus.req_ready_o}, 64'd1);
        chk({tag, "_en"}, {63'd0, rtc_en}, {63'd0, exp_hit});
        chk({tag, "_wext"}, {rtc_wdata[63:32], 24'd0, rtc_we}, {32'd0, 24'd0, 4'b0000, we});
        @(negedge clk);
        chk({tag, "_lat"}, {63'd0, bus.rsp_valid_o}, 64'd1);
        rdata = bus.rsp_rdata_o;
        err   = bus.rsp_err_o;
        bus.req_valid_i = 1'b0;
        bus.req_we_i    = 4'b0000;
        @(negedge clk);
        chk({tag, "_done"}, {63'd0, bus.rsp_valid_o}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset_n     = 1'b0;
        timer_rst_n = 1'b0;
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = BASE;
        bus.req_we_i    = 4'b0000;
        bus.req_wdata_i = 32'h0;
        bus.rsp_ready_i = 1'b1;

        // Reset: requests are ignored and outputs are at reset values
        @(negedge clk);
        chk("rst_en",    {63'd0, rtc_en},          64'd0);
        chk("rst_ready", {63'd0, bus.req_ready_o}, 64'd0);
        chk("rst_valid", {63'd0, bus.rsp_valid_o}, 64'd0);
        chk("rst_rdata", {32'd0, bus.rsp_rdata_o}, 64'd0);
        chk("rst_err",   {63'd0, bus.rsp_err_o},   64'd0);
        @(negedge clk);
        reset_n     = 1'b1;
        timer_rst_n = 1'b1;
        #1;
        chk("rel_ready0", {63'd0, bus.req_ready_o}, 64'd0);
        @(negedge clk);
        chk("rel_ready1", {63'd0, bus.req_ready_o}, 64'd1);
        bus.req_valid_i = 1'b0;
        @(negedge clk);

        // mtimecmp write then read back
        do_req("cmp_wr", BASE + 32'h8, 4'hF, 32'h0000_1000, 1'b1, rd, er);
        chk("cmp_wr_rd", {32'd0, rd}, 64'd0);
        chk("cmp_wr_er", {63'd0, er}, 64'd0);
        do_req("cmp_rd", BASE + 32'h8, 4'h0, 32'h0, 1'b1, rd, er);
        chk("cmp_rd_rd", {32'd0, rd}, 64'h0000_1000);
        chk("cmp_rd_er", {63'd0, er}, 64'd0);

        // Single byte lane into mtimecmp_hi
        do_req("be_wr", BASE + 32'hC, 4'b0001, 32'h1234_56AB, 1'b1, rd, er);
        do_req("be_rd", BASE + 32'hC, 4'h0, 32'h0, 1'b1, rd, er);
        chk("be_rd_rd", {32'd0, rd}, 64'h0000_00AB);

        // Tear-free mtime read across a low-word wrap
        do_req("t_whi", BASE + 32'h4, 4'hF, 32'h0000_0000, 1'b1, rd, er);
        do_req("t_wlo", BASE + 32'h0, 4'hF, 32'hFFFF_FFF0, 1'b1, rd, er);
        do_req("t_rlo", BASE + 32'h0, 4'h0, 32'h0, 1'b1, rd, er);
        chk("t_lo_ge", {63'd0, (rd >= 32'hFFFF_FFF0)}, 64'd1);
        repeat (40) @(negedge clk);
        do_req("t_rhi1", BASE + 32'h4, 4'h0, 32'h0, 1'b1, rd, er);
        chk("t_hi_snap", {32'd0, rd}, 64'h0000_0000);
        do_req("t_rhi2", BASE + 32'h4, 4'h0, 32'h0, 1'b1, rd, er);
        chk("t_hi_live", {32'd0, rd}, 64'h0000_0001);

        // Errors: outside the window and misaligned
        do_req("e_rd", BASE + 32'h10, 4'h0, 32'h0, 1'b0, rd, er);
        chk("e_rd_rd", {32'd0, rd}, 64'd0);
        chk("e_rd_er", {63'd0, er}, 64'd1);
        do_req("e_wr", BASE + 32'h2, 4'hF, 32'hDEAD_BEEF, 1'b0, rd, er);
        chk("e_wr_rd", {32'd0, rd}, 64'd0);
        chk("e_wr_er", {63'd0, er}, 64'd1);

        // Back-pressure on a read response
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = BASE + 32'h8;
        bus.req_we_i    = 4'h0;
        bus.rsp_ready_i = 1'b0;
        @(negedge clk);
        chk("bp_valid", {63'd0, bus.rsp_valid_o}, 64'd1);
        chk("bp_rdata", {32'd0, bus.rsp_rdata_o}, 64'h0000_1000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_v",  {63'd0, bus.rsp_valid_o}, 64'd1);
            chk("bp_hold_d",  {32'd0, bus.rsp_rdata_o}, 64'h0000_1000);
            chk("bp_hold_e",  {63'd0, bus.rsp_err_o},   64'd0);
            chk("bp_hold_rd", {63'd0, bus.req_ready_o}, 64'd0);
            chk("bp_hold_en", {63'd0, rtc_en},          64'd0);
        end
        bus.req_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        chk("bp_rel_v",  {63'd0, bus.rsp_valid_o}, 64'd0);
        chk("bp_rel_rd", {63'd0, bus.req_ready_o}, 64'd1);

        // Reset while a lo-read response is pending drops the snapshot
        do_req("r_whi", BASE + 32'h4, 4'hF, 32'h0000_0002, 1'b1, rd, er);
        do_req("r_wlo", BASE + 32'h0, 4'hF, 32'hFFFF_FFF0, 1'b1, rd, er);
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = BASE;
        bus.req_we_i    = 4'h0;
        bus.rsp_ready_i = 1'b0;
        @(negedge clk);
        chk("r_valid", {63'd0, bus.rsp_valid_o}, 64'd1);
        bus.req_valid_i = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("r_drop_v",  {63'd0, bus.rsp_valid_o}, 64'd0);
        chk("r_drop_rd", {63'd0, bus.req_ready_o}, 64'd0);
        chk("r_drop_d",  {32'd0, bus.rsp_rdata_o}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b1;
        repeat (40) @(negedge clk);
        do_req("r_rhi", BASE + 32'h4, 4'h0, 32'h0, 1'b1, rd, er);
        chk("r_hi_live", {32'd0, rd}, 64'h0000_0003);
        chk("r_hi_er",   {63'd0, er}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
